// File: rtl/writeback_queue.sv
// Writeback stage: round-robin merge of ALU/LSU results into an in-order FIFO that
// retires one register-file write per cycle, plus a per-register pending scoreboard.
module writeback_queue #(
  parameter int DEPTH = 4
) (
  input  logic                     CLK,
  input  logic                     RESET,
  input  logic                     alu_valid,
  input  logic [4:0]               alu_rd,
  input  logic [31:0]              alu_data,
  output logic                     alu_ready,
  input  logic                     lsu_valid,
  input  logic [4:0]               lsu_rd,
  input  logic [31:0]              lsu_data,
  output logic                     lsu_ready,
  input  logic                     issue_valid,
  input  logic [4:0]               issue_rd,
  output logic                     issue_ready,
  input  logic [4:0]               q_rs1,
  input  logic [4:0]               q_rs2,
  output logic                     busy_rs1,
  output logic                     busy_rs2,
  output logic [4:0]               wb_addr,
  output logic [31:0]              wb_data,
  output logic                     wb_en,
  output logic [$clog2(DEPTH):0]   occupancy
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  typedef struct packed {
    logic [4:0]  rd;
    logic [31:0] data;
  } wb_entry_t;

  wb_entry_t         mem_q [DEPTH];
  logic [AW-1:0]     head_q, head_d, tail_q, tail_d;
  logic [AW:0]       occ_q, occ_d;
  logic              last_alu_q, last_alu_d;
  logic [31:0]       pending_q, pending_d;
  logic [4:0]        wb_addr_q, wb_addr_d;
  logic [31:0]       wb_data_q, wb_data_d;
  logic              wb_en_q, wb_en_d;

  logic              full, pop, alu_hs, lsu_hs, push;
  wb_entry_t         push_entry, head_entry;

  assign full       = (occ_q == FULL_CNT);
  assign pop        = (occ_q != '0);
  assign head_entry = mem_q[head_q];

  // Contention goes to whichever side lost the previous grant.
  always_comb begin
    alu_ready = 1'b0;
    lsu_ready = 1'b0;
    if (!full) begin
      if (alu_valid && lsu_valid) begin
        lsu_ready = last_alu_q;
        alu_ready = !last_alu_q;
      end else begin
        alu_ready = alu_valid;
        lsu_ready = lsu_valid;
      end
    end
  end

  assign alu_hs = alu_valid && alu_ready;
  assign lsu_hs = lsu_valid && lsu_ready;

  always_comb begin
    push_entry = lsu_hs ? '{rd: lsu_rd, data: lsu_data} : '{rd: alu_rd, data: alu_data};
    // x0 results are handshaken but never stored.
    push       = (alu_hs || lsu_hs) && (push_entry.rd != 5'd0);
  end

  always_comb begin
    last_alu_d = last_alu_q;
    if (alu_hs)      last_alu_d = 1'b1;
    else if (lsu_hs) last_alu_d = 1'b0;

    head_d = pop  ? head_q + 1'b1 : head_q;
    tail_d = push ? tail_q + 1'b1 : tail_q;
    occ_d  = occ_q + (AW+1)'(push) - (AW+1)'(pop);

    wb_en_d   = pop;
    wb_addr_d = pop ? head_entry.rd   : wb_addr_q;
    wb_data_d = pop ? head_entry.data : wb_data_q;
  end

  // The clear follows the registered write; issue_ready forbids a same-edge set of that reg.
  always_comb begin
    pending_d = pending_q;
    if (wb_en_q)
      pending_d[wb_addr_q] = 1'b0;
    if (issue_valid && issue_ready && (issue_rd != 5'd0))
      pending_d[issue_rd] = 1'b1;
    pending_d[0] = 1'b0;
  end

  assign issue_ready = (issue_rd == 5'd0) || !pending_q[issue_rd];
  assign busy_rs1    = pending_q[q_rs1];
  assign busy_rs2    = pending_q[q_rs2];

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      head_q     <= '0;
      tail_q     <= '0;
      occ_q      <= '0;
      last_alu_q <= 1'b1;
      pending_q  <= '0;
      wb_en_q    <= 1'b0;
      wb_addr_q  <= '0;
      wb_data_q  <= '0;
    end else begin
      head_q     <= head_d;
      tail_q     <= tail_d;
      occ_q      <= occ_d;
      last_alu_q <= last_alu_d;
      pending_q  <= pending_d;
      wb_en_q    <= wb_en_d;
      wb_addr_q  <= wb_addr_d;
      wb_data_q  <= wb_data_d;
    end
  end

  // Storage is qualified by occupancy, so it needs no reset.
  always_ff @(posedge CLK) begin
    if (push)
      mem_q[tail_q] <= push_entry;
  end

  assign wb_en     = wb_en_q;
  assign wb_addr   = wb_addr_q;
  assign wb_data   = wb_data_q;
  assign occupancy = occ_q;

endmodule
